seg_score_decoder: RTL and testbench
====================================

Name: seg_score_decoder

Overview:
- Receive side of the multiplexed two-digit 7-segment score interface.
- Samples the time-multiplexed segment and digit-select lines driven by the score display block and reconstructs the displayed two-digit BCD value.
- Filters for stability and flags illegal patterns and stalled scanning.
- Used as a bench/self-check monitor and for score readback on chips without a physical display.

Parameters:
STABLE_SAMPLES, 2, consecutive identical decodes of a digit required before it is committed (range 1-15).
TIMEOUT, 1024, clocks with no legal digit-select before lock is dropped (range 2-65535).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
segments  input  7  {g,f,e,d,c,b,a} from the display driver
digits  input  2  digit select: bit0 = ones digit, bit1 = tens digit (non-inverted sense)
invert  input  1  1 = common-anode polarity; segments and digits are both active-low
ones  output  4  committed ones digit: 0-9, or 15 = blank
tens  output  4  committed tens digit: 0-9, or 15 = blank
valid  output  1  both digits committed and scan alive
blank  output  1  valid and both digits blank
changed  output  1  one-cycle pulse when the {tens,ones} pair is updated
illegal  output  1  one-cycle pulse: illegal segment pattern or digit select
err_count  output  8  saturating count of illegal events

Behaviour:
- Reset (async, rst_n=0): ones=15, tens=15, valid=0, blank=0, changed=0, illegal=0, err_count=0. All candidates and counters are cleared and the FSM enters SYNC. Reset asserted mid-frame discards all partial state.
- Stage 1: segments, digits and invert are registered every clock with no qualification.
- Stage 2 (next edge): the registered sample is normalized:
  - s = invert ? ~segments : segments
  - d = invert ? ~digits : digits
- Digit select:
  - d=01 selects ones; d=10 selects tens.
  - d=00 or d=11: illegal pulse, sample ignored.
- Decode of s:
  - 0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4, 1101101=5, 1111101=6, 0000111=7, 1111111=8, 1101111=9, 0000000=15 (blank).
  - Any other pattern: illegal pulse; that digit's candidate count is cleared; committed value unchanged.
- Per-digit candidate: a 4-bit value plus a 4-bit match count.
  - A legal decode equal to the candidate increments the count, saturating at STABLE_SAMPLES.
  - A different value loads the candidate with count=1.
  - When the count reaches STABLE_SAMPLES and the candidate differs from the committed digit, the committed digit takes the candidate.
  - The digit's "seen" flag is set on its first commit.
- Commit timing: committed outputs update at the Stage 2 edge, i.e. 2 clocks after the completing sample is presented on the inputs.
- changed pulses in that same cycle if {tens,ones} differs from the previous value.
  - The first commit after reset pulses changed only if the value differs from the reset value 15/15.
- FSM:
  - SYNC: valid=0. Go to LOCKED when both seen flags are set.
  - LOCKED: valid=1. Return to SYNC when the stall counter reaches TIMEOUT.
  - On entering SYNC from LOCKED: seen flags and candidates are cleared. Committed digits are held but are not trusted until re-lock.
- Stall counter:
  - Cleared by any legal digit select, otherwise increments.
  - Saturates at TIMEOUT and is active in both states.
  - A legal select in the same cycle as the counter reaching TIMEOUT wins: no drop.
- blank = valid & (ones==15) & (tens==15).
- err_count increments on each illegal pulse and saturates at 255.
  - At most one increment per cycle, even if the select and the pattern are both bad.
- Back-to-back same-digit samples are legal. Each counts toward stability; alternation is not required.

Test Plan:
- Score 37, invert=0, alternating {0000111,01},{1001111,10} from cycle 0 -> tens=3 commits at clock 5, valid=1 at clock 6, changed pulses once, ones=7, illegal never.
- Same score with invert=1 (segments {1111000,10},{0110000,01}) -> identical outputs to the invert=0 case.
- Stable 37, then the ones digit shows 8 for one sample and returns to 7 (STABLE_SAMPLES=2) -> ones stays 7 and changed stays 0. Then 8 is held for two samples -> ones=8 and changed pulses exactly once.
- Inject segments=1010101 with digits=01, then digits=11 with a legal pattern -> two illegal pulses, err_count=2, committed values unchanged, valid stays 1.
- Both digits 0000000 (score display disabled) -> ones=15, tens=15, valid=1, blank=1. Then hold digits=00 for TIMEOUT clocks -> valid=0, blank=0; resume scanning -> re-lock after both digits are seen again.
- Assert rst_n low mid-frame with score 99 committed -> immediately ones=15, tens=15, valid=0, err_count=0. After release, lock is re-acquired normally.

Source files
------------

// File: rtl/seg_score_decoder.sv
// -----------------------------------------------------------------------------
// seg_score_decoder
//
// Receive side of the multiplexed two-digit 7-segment score interface. It
// samples the time-multiplexed segment and digit-select lines and rebuilds
// the two-digit BCD score shown on the display. Each digit has to decode
// identically several times before it is committed. The block also flags
// illegal patterns and illegal selects, and drops lock when scanning stalls.
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   segments   : {g,f,e,d,c,b,a} from the display driver
//   digits     : digit select, bit0 = ones, bit1 = tens
//   invert     : 1 = common-anode polarity (segments and digits active-low)
//   ones       : committed ones digit, 0-9 or 15 = blank
//   tens       : committed tens digit, 0-9 or 15 = blank
//   valid      : both digits committed and scanning alive
//   blank      : valid and both digits blank
//   changed    : one-cycle pulse when {tens,ones} is updated
//   illegal    : one-cycle pulse on an illegal pattern or digit select
//   err_count  : saturating count of illegal events
// -----------------------------------------------------------------------------
module seg_score_decoder #(
   parameter int unsigned STABLE_SAMPLES = 2,     // 1..15
   parameter int unsigned TIMEOUT        = 1024   // 2..65535
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] segments,
   input  logic [1:0] digits,
   input  logic       invert,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic       valid,
   output logic       blank,
   output logic       changed,
   output logic       illegal,
   output logic [7:0] err_count
);

   localparam logic [3:0]  STABLE_N  = 4'(STABLE_SAMPLES);
   localparam logic [15:0] TIMEOUT_N = 16'(TIMEOUT);
   localparam logic [3:0]  BLANK_VAL = 4'hF;

   typedef enum logic {
      SYNC   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   // Returns {legal, value}. The all-off pattern is a legal blank digit.
   function automatic logic [4:0] decode(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'b0111111: r = {1'b1, 4'd0};
         7'b0000110: r = {1'b1, 4'd1};
         7'b1011011: r = {1'b1, 4'd2};
         7'b1001111: r = {1'b1, 4'd3};
         7'b1100110: r = {1'b1, 4'd4};
         7'b1101101: r = {1'b1, 4'd5};
         7'b1111101: r = {1'b1, 4'd6};
         7'b0000111: r = {1'b1, 4'd7};
         7'b1111111: r = {1'b1, 4'd8};
         7'b1101111: r = {1'b1, 4'd9};
         7'b0000000: r = {1'b1, BLANK_VAL};
         default:    r = {1'b0, 4'd0};
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Stage 1: raw capture of the interface lines
   // ---------------------------------------------------------------------------
   logic [6:0] seg_q;
   logic [1:0] dig_q;
   logic       inv_q;
   logic       s1_vld_q;   // stage 1 holds a real sample (not the reset value)

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q    <= '0;
         dig_q    <= '0;
         inv_q    <= 1'b0;
         s1_vld_q <= 1'b0;
      end else begin
         seg_q    <= segments;
         dig_q    <= digits;
         inv_q    <= invert;
         s1_vld_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: normalize, decode, and filter per digit (index 0 = ones, 1 = tens)
   // ---------------------------------------------------------------------------
   logic [6:0] s_norm;
   logic [1:0] d_norm;
   logic       sel_ok;
   logic       sel_idx;
   logic       pat_ok;
   logic [3:0] pat_val;

   assign s_norm  = inv_q ? ~seg_q : seg_q;
   assign d_norm  = inv_q ? ~dig_q : dig_q;
   assign sel_ok  = (d_norm == 2'b01) || (d_norm == 2'b10);
   assign sel_idx = d_norm[1];
   assign {pat_ok, pat_val} = decode(s_norm);

   state_e      state_q;
   logic [3:0]  cand_q  [2];
   logic [3:0]  cnt_q   [2];
   logic [3:0]  digit_q [2];
   logic        seen_q  [2];
   logic [15:0] stall_q;

   logic [3:0]  cand_d  [2];
   logic [3:0]  cnt_d   [2];
   logic [3:0]  digit_d [2];
   logic        seen_d  [2];
   logic [15:0] stall_d;
   logic        commit;
   logic        bad;
   logic        drop;

   // NOTE: every variable gets a default at the top of the block, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      digit_d = digit_q;
      seen_d  = seen_q;
      stall_d = stall_q;
      commit  = 1'b0;
      bad     = 1'b0;

      if (s1_vld_q) begin
         // A bad select and a bad pattern in the same sample are one event.
         bad = !sel_ok || !pat_ok;

         if (sel_ok)
            stall_d = '0;
         else if (stall_q != TIMEOUT_N)
            stall_d = stall_q + 16'd1;

         if (sel_ok) begin
            if (!pat_ok) begin
               cnt_d[sel_idx] = '0;
            end else if (pat_val == cand_q[sel_idx]) begin
               if (cnt_q[sel_idx] != STABLE_N)
                  cnt_d[sel_idx] = cnt_q[sel_idx] + 4'd1;
            end else begin
               cand_d[sel_idx] = pat_val;
               cnt_d[sel_idx]  = 4'd1;
            end

            // A stable value marks the digit as seen even when it matches
            // what is already committed, so re-lock onto an unchanged score
            // is still possible after a stall.
            if (pat_ok && cnt_d[sel_idx] == STABLE_N) begin
               seen_d[sel_idx] = 1'b1;
               if (cand_d[sel_idx] != digit_q[sel_idx]) begin
                  digit_d[sel_idx] = cand_d[sel_idx];
                  commit           = 1'b1;
               end
            end
         end
      end

      // A legal select clears stall_d, so it always beats the timeout.
      drop = (state_q == LOCKED) && (stall_d == TIMEOUT_N);
   end

   // ---------------------------------------------------------------------------
   // Stage 2 registers, lock FSM and registered outputs
   // ---------------------------------------------------------------------------
   // NOTE: the per-digit arrays are only two entries deep and must come out of
   // reset in a known state, so they are reset like ordinary flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SYNC;
         stall_q   <= '0;
         for (int i = 0; i < 2; i++) begin
            cand_q[i]  <= BLANK_VAL;
            cnt_q[i]   <= '0;
            digit_q[i] <= BLANK_VAL;
            seen_q[i]  <= 1'b0;
         end
         valid     <= 1'b0;
         blank     <= 1'b0;
         changed   <= 1'b0;
         illegal   <= 1'b0;
         err_count <= '0;
      end else begin
         stall_q <= stall_d;
         digit_q <= digit_d;
         changed <= commit;
         illegal <= bad;
         if (bad && err_count != 8'hFF)
            err_count <= err_count + 8'd1;

         // Leaving LOCKED throws away all filter history; the committed
         // digits stay on the outputs but are untrusted until re-lock.
         if (drop) begin
            for (int i = 0; i < 2; i++) begin
               cand_q[i] <= BLANK_VAL;
               cnt_q[i]  <= '0;
               seen_q[i] <= 1'b0;
            end
         end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            seen_q <= seen_d;
         end

         case (state_q)
            SYNC: begin
               if (seen_q[0] && seen_q[1]) begin
                  state_q <= LOCKED;
                  valid   <= 1'b1;
                  blank   <= (digit_d[0] == BLANK_VAL) && (digit_d[1] == BLANK_VAL);
               end else begin
                  valid <= 1'b0;
                  blank <= 1'b0;
               end
            end
            LOCKED: begin
               if (drop) begin
                  state_q <= SYNC;
                  valid   <= 1'b0;
                  blank   <= 1'b0;
               end else begin
                  valid <= 1'b1;
                  blank <= (digit_d[0] == BLANK_VAL) && (digit_d[1] == BLANK_VAL);
               end
            end
            default: begin
               state_q <= SYNC;
               valid   <= 1'b0;
               blank   <= 1'b0;
            end
         endcase
      end
   end

   assign ones = digit_q[0];
   assign tens = digit_q[1];

endmodule

// File: tb/tb_seg_score_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_score_decoder
//
// Directed bench for seg_score_decoder (STABLE_SAMPLES=2, TIMEOUT=16).
// Inputs change on the falling edge and outputs are sampled there too.
// A sample driven in step N is captured at that step's rising edge and
// decoded at the rising edge of step N+1.
// -----------------------------------------------------------------------------
module tb_seg_score_decoder;

   localparam logic [6:0] P2  = 7'b1011011;
   localparam logic [6:0] P3  = 7'b1001111;
   localparam logic [6:0] P4  = 7'b1100110;
   localparam logic [6:0] P7  = 7'b0000111;
   localparam logic [6:0] P8  = 7'b1111111;
   localparam logic [6:0] P9  = 7'b1101111;
   localparam logic [6:0] PBL = 7'b0000000;
   localparam logic [6:0] PBAD = 7'b1010101;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] segments = '0;
   logic [1:0] digits = '0;
   logic       invert = 1'b0;
   logic [3:0] ones, tens;
   logic       valid, blank, changed, illegal;
   logic [7:0] err_count;

   int n_assert = 0;
   int n_fail   = 0;
   int pulses;

   seg_score_decoder #(
      .STABLE_SAMPLES(2),
      .TIMEOUT(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .segments(segments),
      .digits(digits),
      .invert(invert),
      .ones(ones),
      .tens(tens),
      .valid(valid),
      .blank(blank),
      .changed(changed),
      .illegal(illegal),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [6:0] seg, input logic [1:0] dig, input logic inv);
      segments = seg;
      digits   = dig;
      invert   = inv;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic s_ones(input logic [6:0] seg);
      step(seg, 2'b01, 1'b0);
   endtask

   task automatic s_tens(input logic [6:0] seg);
      step(seg, 2'b10, 1'b0);
   endtask

   task automatic do_reset(input string tag);
      rst_n    = 1'b0;
      segments = '0;
      digits   = '0;
      invert   = 1'b0;
      repeat (2) @(negedge clk);
      check({tag, "_rst_ones"},  ones,      15);
      check({tag, "_rst_tens"},  tens,      15);
      check({tag, "_rst_valid"}, valid,     0);
      check({tag, "_rst_blank"}, blank,     0);
      check({tag, "_rst_chg"},   changed,   0);
      check({tag, "_rst_ill"},   illegal,   0);
      check({tag, "_rst_err"},   err_count, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---------------- Score 37, non-inverted ----------------
      do_reset("t1");
      s_ones(P7);
      s_tens(P3);
      s_ones(P7);
      check("t1_early_ones", ones, 15);
      check("t1_early_chg",  changed, 0);
      s_tens(P3);
      check("t1_ones7",      ones, 7);
      check("t1_tens_pend",  tens, 15);
      check("t1_chg_ones",   changed, 1);
      check("t1_nolock",     valid, 0);
      s_ones(P7);
      check("t1_tens3",      tens, 3);
      check("t1_chg_tens",   changed, 1);
      check("t1_valid_late", valid, 0);
      s_tens(P3);
      check("t1_valid",      valid, 1);
      check("t1_chg_idle",   changed, 0);
      check("t1_blank",      blank, 0);
      check("t1_illegal",    illegal, 0);
      check("t1_err",        err_count, 0);

      // ---------------- Score 37, inverted polarity ----------------
      do_reset("t2");
      step(~P7, 2'b10, 1'b1);
      step(~P3, 2'b01, 1'b1);
      step(~P7, 2'b10, 1'b1);
      step(~P3, 2'b01, 1'b1);
      check("t2_ones7",   ones, 7);
      check("t2_chg",     changed, 1);
      step(~P7, 2'b10, 1'b1);
      check("t2_tens3",   tens, 3);
      check("t2_valid0",  valid, 0);
      step(~P3, 2'b01, 1'b1);
      check("t2_valid",   valid, 1);
      check("t2_err",     err_count, 0);

      // ---------------- Glitch rejection, then a real change ----------------
      pulses = 0;
      s_ones(P8); pulses += int'(changed);
      s_tens(P3); pulses += int'(changed);
      s_ones(P7); pulses += int'(changed);
      s_tens(P3); pulses += int'(changed);
      s_ones(P7); pulses += int'(changed);
      s_tens(P3); pulses += int'(changed);
      check("t3_glitch_ones", ones, 7);
      check("t3_glitch_chg",  pulses, 0);
      s_ones(P8); pulses += int'(changed);
      s_tens(P3); pulses += int'(changed);
      s_ones(P8); pulses += int'(changed);
      s_tens(P3); pulses += int'(changed);
      s_ones(P8); pulses += int'(changed);
      check("t3_ones8",   ones, 8);
      check("t3_tens3",   tens, 3);
      check("t3_pulses",  pulses, 1);
      check("t3_valid",   valid, 1);

      // ---------------- Illegal pattern and illegal select ----------------
      s_ones(PBAD);
      step(P3, 2'b11, 1'b0);
      check("t4_ill_pat",   illegal, 1);
      check("t4_err1",      err_count, 1);
      s_tens(P3);
      check("t4_ill_sel",   illegal, 1);
      check("t4_err2",      err_count, 2);
      s_ones(P8);
      check("t4_ill_clear", illegal, 0);
      check("t4_err_hold",  err_count, 2);
      check("t4_ones",      ones, 8);
      check("t4_tens",      tens, 3);
      check("t4_valid",     valid, 1);

      // ---------------- Blank display, stall timeout, re-lock ----------------
      s_tens(PBL);
      s_ones(PBL);
      s_tens(PBL);
      s_ones(PBL);
      s_tens(PBL);
      check("t5_ones15", ones, 15);
      check("t5_tens15", tens, 15);
      check("t5_valid",  valid, 1);
      check("t5_blank",  blank, 1);
      for (int i = 0; i < 16; i++) step(PBL, 2'b00, 1'b0);
      check("t5_pre_drop_valid", valid, 1);
      check("t5_pre_drop_err",   err_count, 17);
      step(PBL, 2'b00, 1'b0);
      check("t5_drop_valid", valid, 0);
      check("t5_drop_blank", blank, 0);
      check("t5_drop_err",   err_count, 18);
      check("t5_hold_ones",  ones, 15);
      s_ones(P2);
      s_tens(P4);
      s_ones(P2);
      s_tens(P4);
      s_ones(P2);
      check("t5_re_ones",   ones, 2);
      check("t5_re_tens",   tens, 4);
      check("t5_re_wait",   valid, 0);
      s_tens(P4);
      check("t5_relock",    valid, 1);
      check("t5_re_blank",  blank, 0);
      check("t5_re_err",    err_count, 19);

      // ---------------- Reset mid-frame with 99 committed ----------------
      s_ones(P9);
      s_tens(P9);
      s_ones(P9);
      s_tens(P9);
      s_ones(P9);
      check("t6_ones9", ones, 9);
      check("t6_tens9", tens, 9);
      check("t6_valid", valid, 1);
      segments = P9;
      digits   = 2'b10;
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_ones",  ones, 15);
      check("t6_async_tens",  tens, 15);
      check("t6_async_valid", valid, 0);
      check("t6_async_err",   err_count, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      s_ones(P7);
      s_tens(P3);
      s_ones(P7);
      s_tens(P3);
      s_ones(P7);
      s_tens(P3);
      check("t6_relock_valid", valid, 1);
      check("t6_relock_ones",  ones, 7);
      check("t6_relock_tens",  tens, 3);
      check("t6_relock_err",   err_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
